// File: rtl/isqrt_iter.sv
// isqrt_iter: iterative restoring square root, STEPS root bits per clock, valid/ready on both sides
module isqrt_iter #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem,
    output logic             exact,
    output logic             busy
);
    localparam int RW = WIDTH / 2;
    localparam int ITER = RW / STEPS;
    localparam int CW = ITER > 1 ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state;
    logic [WIDTH-1:0] sh, sh_n;
    logic [RW-1:0] q, q_n;
    logic [RW+1:0] r, r_n, t;
    logic [CW-1:0] cnt;

    // STEPS unrolled restoring sub-steps; r is RW+2 bits wide so the trial subtraction cannot wrap
    always_comb begin
        sh_n = sh;
        q_n = q;
        r_n = r;
        t = '0;
        for (int i = 0; i < STEPS; i++) begin
            r_n = {r_n[RW-1:0], sh_n[WIDTH-1 -: 2]};
            t = {q_n, 2'b01};
            if (r_n >= t) begin
                r_n = r_n - t;
                q_n = {q_n[RW-2:0], 1'b1};
            end else begin
                q_n = {q_n[RW-2:0], 1'b0};
            end
            sh_n = sh_n << 2;
        end
    end

    // Control FSM with registered handshake outputs and result registers held through DONE
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            busy <= 1'b0;
            root <= '0;
            rem <= '0;
            exact <= 1'b0;
            cnt <= '0;
            sh <= '0;
            q <= '0;
            r <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sh <= n;
                    q <= '0;
                    r <= '0;
                    cnt <= CW'(ITER - 1);
                    state <= CALC;
                    in_ready <= 1'b0;
                    busy <= 1'b1;
                end
                CALC: begin
                    sh <= sh_n;
                    q <= q_n;
                    r <= r_n;
                    if (cnt == '0) begin
                        root <= q_n;
                        rem <= r_n[RW:0];
                        exact <= (r_n == '0);
                        out_valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_isqrt_iter.sv
// tb_isqrt_iter: scoreboard bench for a 32-bit/1-step and a 16-bit/2-step square root
module tb_isqrt_iter;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    logic iv_a = 1'b0, or_a = 1'b0;
    logic ir_a, ov_a, ex_a, busy_a;
    logic [31:0] n_a = '0;
    logic [15:0] root_a;
    logic [16:0] rem_a;

    logic iv_b = 1'b0, or_b = 1'b0;
    logic ir_b, ov_b, ex_b, busy_b;
    logic [15:0] n_b = '0;
    logic [7:0] root_b;
    logic [8:0] rem_b;

    typedef struct {
        logic [31:0] n;
        logic [15:0] root;
        logic [16:0] rem;
        logic exact;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int failures = 0;

    isqrt_iter #(.WIDTH(32), .STEPS(1)) dut_a (
        .CLK(CLK), .RST(RST), .in_valid(iv_a), .in_ready(ir_a), .n(n_a),
        .out_valid(ov_a), .out_ready(or_a), .root(root_a), .rem(rem_a),
        .exact(ex_a), .busy(busy_a)
    );

    isqrt_iter #(.WIDTH(16), .STEPS(2)) dut_b (
        .CLK(CLK), .RST(RST), .in_valid(iv_b), .in_ready(ir_b), .n(n_b),
        .out_valid(ov_b), .out_ready(or_b), .root(root_b), .rem(rem_b),
        .exact(ex_b), .busy(busy_b)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] v, input int rw);
        exp_t e;
        longint unsigned rt = 0;
        longint unsigned c;
        longint unsigned d;
        for (int b = rw - 1; b >= 0; b--) begin
            c = rt | (64'd1 << b);
            if (c * c <= {32'd0, v}) rt = c;
        end
        d = {32'd0, v} - rt * rt;
        e.n = v;
        e.root = rt[15:0];
        e.rem = d[16:0];
        e.exact = (d == 0);
        return e;
    endfunction

    task automatic send_a(input logic [31:0] v);
        int lim = 0;
        @(negedge CLK);
        iv_a = 1'b1;
        n_a = v;
        while (!ir_a && lim < 100) begin
            @(negedge CLK);
            lim++;
        end
        @(posedge CLK);
        qa.push_back(model(v, 16));
        @(negedge CLK);
        iv_a = 1'b0;
        n_a = $urandom;
    endtask

    task automatic send_b(input logic [15:0] v);
        int lim = 0;
        @(negedge CLK);
        iv_b = 1'b1;
        n_b = v;
        while (!ir_b && lim < 100) begin
            @(negedge CLK);
            lim++;
        end
        @(posedge CLK);
        qb.push_back(model({16'd0, v}, 8));
        @(negedge CLK);
        iv_b = 1'b0;
        n_b = 16'($urandom);
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (!ov_a && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (!ov_b && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic release_a();
        or_a = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        or_a = 1'b0;
    endtask

    task automatic release_b();
        or_b = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        or_b = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (ir_a !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir_a); end
        checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (root_a !== 16'd0) begin failures++; $display("FAIL reset_root got=%0d exp=0", root_a); end
        checks++; if (rem_a !== 17'd0) begin failures++; $display("FAIL reset_rem got=%0d exp=0", rem_a); end
        checks++; if (ex_a !== 1'b0) begin failures++; $display("FAIL reset_exact got=%b exp=0", ex_a); end
        checks++; if (ir_b !== 1'b1 || ov_b !== 1'b0) begin failures++; $display("FAIL reset_b ir=%b ov=%b exp ir=1 ov=0", ir_b, ov_b); end
        RST = 1'b1;
    endtask

    task automatic test_zero();
        int lat;
        exp_t e;
        send_a(32'd0);
        wait_a(lat);
        e = qa.pop_front();
        checks++; if (lat !== 16) begin failures++; $display("FAIL zero_latency got=%0d exp=16", lat); end
        checks++; if (root_a !== 16'd0 || root_a !== e.root) begin failures++; $display("FAIL zero_root got=%0d exp=0", root_a); end
        checks++; if (rem_a !== 17'd0) begin failures++; $display("FAIL zero_rem got=%0d exp=0", rem_a); end
        checks++; if (ex_a !== 1'b1) begin failures++; $display("FAIL zero_exact got=%b exp=1", ex_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL zero_busy_done got=%b exp=1", busy_a); end
        release_a();
        checks++; if (ir_a !== 1'b1 || ov_a !== 1'b0) begin failures++; $display("FAIL zero_handoff ir=%b ov=%b exp ir=1 ov=0", ir_a, ov_a); end
    endtask

    task automatic test_values();
        logic [31:0] vals [0:5] = '{32'd144, 32'd145, 32'hFFFF_FFFF, 32'd1, 32'd3, 32'hFFFE_0001};
        logic [15:0] roots [0:5] = '{16'd12, 16'd12, 16'd65535, 16'd1, 16'd1, 16'd65535};
        logic [16:0] rems [0:5] = '{17'd0, 17'd1, 17'd131070, 17'd0, 17'd2, 17'd0};
        int lat;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            send_a(vals[i]);
            wait_a(lat);
            e = qa.pop_front();
            checks++; if (lat !== 16) begin failures++; $display("FAIL val_latency n=%0d got=%0d exp=16", vals[i], lat); end
            checks++; if (root_a !== roots[i] || root_a !== e.root) begin failures++; $display("FAIL val_root n=%0d got=%0d exp=%0d", vals[i], root_a, roots[i]); end
            checks++; if (rem_a !== rems[i] || rem_a !== e.rem) begin failures++; $display("FAIL val_rem n=%0d got=%0d exp=%0d", vals[i], rem_a, rems[i]); end
            checks++; if (ex_a !== (rems[i] == 0)) begin failures++; $display("FAIL val_exact n=%0d got=%b exp=%b", vals[i], ex_a, rems[i] == 0); end
            release_a();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        send_a(32'd1000);
        wait_a(lat);
        e = qa.pop_front();
        iv_a = 1'b1;
        n_a = 32'd50;
        for (int i = 0; i < 20; i++) begin
            checks++; if (ov_a !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, ov_a); end
            checks++; if (root_a !== 16'd31 || root_a !== e.root) begin failures++; $display("FAIL bp_root cyc=%0d got=%0d exp=31", i, root_a); end
            checks++; if (rem_a !== 17'd39) begin failures++; $display("FAIL bp_rem cyc=%0d got=%0d exp=39", i, rem_a); end
            checks++; if (ir_a !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, ir_a); end
            @(negedge CLK);
        end
        release_a();
        checks++; if (ov_a !== 1'b0 || ir_a !== 1'b1) begin failures++; $display("FAIL bp_release ov=%b ir=%b exp ov=0 ir=1", ov_a, ir_a); end
        @(posedge CLK);
        qa.push_back(model(32'd50, 16));
        @(negedge CLK);
        iv_a = 1'b0;
        checks++; if (ir_a !== 1'b0) begin failures++; $display("FAIL bp_accept in_ready=%b exp=0", ir_a); end
        wait_a(lat);
        e = qa.pop_front();
        checks++; if (lat !== 16) begin failures++; $display("FAIL bp2_latency got=%0d exp=16", lat); end
        checks++; if (root_a !== e.root || rem_a !== e.rem || root_a !== 16'd7) begin failures++; $display("FAIL bp2_result root=%0d rem=%0d exp root=7 rem=1", root_a, rem_a); end
        release_a();
    endtask

    task automatic test_reset_mid();
        int lat;
        int rose = 0;
        exp_t e;
        send_a(32'd99);
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++; if (ov_a !== 1'b0 || busy_a !== 1'b0 || ir_a !== 1'b1) begin failures++; $display("FAIL rmid_ctrl ov=%b busy=%b ir=%b exp 0 0 1", ov_a, busy_a, ir_a); end
        checks++; if (root_a !== 16'd0 || rem_a !== 17'd0 || ex_a !== 1'b0) begin failures++; $display("FAIL rmid_outputs root=%0d rem=%0d exact=%b exp 0 0 0", root_a, rem_a, ex_a); end
        qa.delete();
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (ov_a) rose++;
        end
        checks++; if (rose !== 0) begin failures++; $display("FAIL rmid_no_output cycles_valid=%0d exp=0", rose); end
        send_a(32'd81);
        wait_a(lat);
        e = qa.pop_front();
        checks++; if (lat !== 16) begin failures++; $display("FAIL rmid_latency got=%0d exp=16", lat); end
        checks++; if (root_a !== 16'd9 || root_a !== e.root) begin failures++; $display("FAIL rmid_root got=%0d exp=9", root_a); end
        checks++; if (rem_a !== 17'd0 || ex_a !== 1'b1) begin failures++; $display("FAIL rmid_rem rem=%0d exact=%b exp 0 1", rem_a, ex_a); end
        release_a();
    endtask

    task automatic test_random_b();
        int lat;
        exp_t e;
        logic [15:0] v;
        int unsigned s;
        for (int i = 0; i < 1000; i++) begin
            v = (i == 0) ? 16'd0 : (i == 1) ? 16'hFFFF : (i == 2) ? 16'd16384 : 16'($urandom_range(0, 65535));
            send_b(v);
            wait_b(lat);
            e = qb.pop_front();
            s = 32'(root_b) * 32'(root_b) + 32'(rem_b);
            checks++; if (lat !== 4) begin failures++; $display("FAIL b_latency n=%0d got=%0d exp=4", v, lat); end
            checks++; if (root_b !== e.root[7:0]) begin failures++; $display("FAIL b_root n=%0d got=%0d exp=%0d", v, root_b, e.root); end
            checks++; if (rem_b !== e.rem[8:0] || ex_b !== e.exact) begin failures++; $display("FAIL b_rem n=%0d got=%0d/%b exp=%0d/%b", v, rem_b, ex_b, e.rem, e.exact); end
            checks++; if (s !== {16'd0, v}) begin failures++; $display("FAIL b_identity n=%0d got=%0d exp=%0d", v, s, v); end
            checks++; if (32'(rem_b) > 2 * 32'(root_b)) begin failures++; $display("FAIL b_rem_range n=%0d rem=%0d max=%0d", v, rem_b, 2 * root_b); end
            release_b();
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_backpressure();
        test_reset_mid();
        test_random_b();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
